vga_pixel_out: RTL and testbench
================================

Name: vga_pixel_out

Overview:
- VGA timing generator and output stage that drives the ordered-dither colour reducer and consumes its result.
- Generates the horizontal/vertical counters and the pixel request, and supplies the hc/vc parity bits to the dither stage.
- Registers the returned 24-bit pixel, keeps the upper nibble of each channel for the 4-bit DACs, and aligns the data with HSYNC/VSYNC.
- Sits between the framebuffer read port / dither stage and the board VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low pulses)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- pix_ce  in  1  pixel-clock enable; all state except frame_start advances only when high
- pix_x  out  10  column of the pixel currently requested
- pix_y  out  10  row of the pixel currently requested
- pix_req  out  1  high when (pix_x, pix_y) is inside the active area
- hc  out  1  pix_x[0], parity to the dither stage
- vc  out  1  pix_y[0], parity to the dither stage
- pix_in  in  24  dithered RGB888 returned one ce-tick after the request; only [23:20], [15:12], [7:4] are used
- vga_r  out  4  red DAC
- vga_g  out  4  green DAC
- vga_b  out  4  blue DAC
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- frame_start  out  1  one-clk pulse at the first ce-tick of a frame

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Counter widths are clog2(H_TOTAL) and clog2(V_TOTAL), zero-extended onto the 10-bit ports.
- Stage 0 (counters), on each ce-tick:
  - hcount increments; when hcount = H_TOTAL-1 it wraps to 0 and vcount increments.
  - When vcount = V_TOTAL-1 and hcount wraps, vcount also wraps to 0.
  - pix_x = hcount, pix_y = vcount, hc/vc taken combinationally from the counters.
  - pix_req = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- Sync windows:
  - hs_raw is asserted for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is asserted for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC.
  - The asserted pin level is SYNC_POL.
- Stage 1: on a ce-tick, register pix_in nibbles, pix_req, hs_raw and vs_raw. pix_in is the response to the request made on the previous ce-tick.
- Stage 2: on a ce-tick, drive vga_r/g/b from the stage-1 nibbles if the stage-1 active bit is set, else 4'h0; drive vga_hs/vga_vs from the stage-1 sync bits.
- Latency: 2 ce-ticks from counter value to pins, identical for colour and sync, so the sync/colour phase is preserved.
- pix_ce low: every register holds; outputs stay stable. pix_ce high continuously is legal (pixel clock equals clk).
- frame_start is 1 for exactly one clk when a ce-tick occurs with hcount=0 and vcount=0. It is 0 in all other cycles, including held cycles.
- Reset (async assert, sync release):
  - counters and pipeline cleared; vga_r/g/b = 0; vga_hs/vga_vs = !SYNC_POL; frame_start = 0.
  - pix_x = pix_y = 0, pix_req = 1, hc = vc = 0.
- Reset mid-frame: restarts at (0,0). The first frame_start is on the first ce-tick after release.

Optional Feature:
- Macro: VGA_TEMPORAL_DITHER_EN.
- With it defined:
  - A 1-bit frame_par register toggles on each frame wrap; reset value 0.
  - hc = pix_x[0] ^ frame_par and vc = pix_y[0] ^ frame_par, so the dither pattern alternates between frames.
- Without it: frame_par does not exist; hc = pix_x[0], vc = pix_y[0].

Decomposition:
- Shared package vga_pkg holds:
  - timing localparams H_TOTAL, V_TOTAL;
  - typedef rgb444_t (packed r, g, b, each 4 bits);
  - typedef vga_sync_t (hs, vs, act).
- One natural sub-module, vga_timing: stage-0 counters, sync windows, pix_req and frame_start.
- The top level keeps the two-stage data/sync pipeline.

Test Plan:
- Reset then 2 full frames with pix_ce=1:
  - 800 clk between vga_hs falling edges; hs low for 96 clk;
  - vs low for 2×800 clk; frame period 420000 clk.
- pix_in=24'hA5C3F0 held:
  - during active area vga_r=A, vga_g=C, vga_b=F;
  - first non-zero colour at pin appears 2 clk after pix_req rises at (0,0);
  - colour is 0 on the 2 ticks after pix_req falls.
- pix_ce=1 every 4th clk:
  - all periods scale ×4;
  - frame_start is high for exactly 1 clk per frame;
  - outputs are constant between ce-ticks.
- hc/vc check:
  - at (5,2): hc=1, vc=0;
  - at (6,3): hc=0, vc=1;
  - with VGA_TEMPORAL_DITHER_EN, the same points on frame 2 give hc=0, vc=1 and hc=1, vc=0.
- Assert rst_n low at (300,200) for 3 clk:
  - outputs immediately 0 / sync high;
  - after release the counter resumes at (0,0) and frame_start pulses on the first ce-tick.
- SYNC_POL=1 build: reset sync level 0; pulses high with the same widths.

Source files
------------

// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared timing constants and datapath types for the VGA output
//            stage (timing generator and pixel pipeline).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int unsigned H_TOTAL = 640 + 16 + 96 + 48;
    localparam int unsigned V_TOTAL = 480 + 10 + 2 + 33;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } vga_sync_t;

    // The 4-bit DACs only see the top nibble of each RGB888 channel.
    function automatic rgb444_t rgb_nibbles(input logic [23:0] px);
        rgb444_t res;
        res.r = px[23:20];
        res.g = px[15:12];
        res.b = px[7:4];
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing.sv
// ============================================================================
// Module   : vga_timing
// Brief    : Stage-0 horizontal/vertical counters, raw sync windows, pixel
//            request, dither parity bits and frame_start pulse.
//            Optional macro: VGA_TEMPORAL_DITHER_EN (per-frame parity flip).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_ce,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       hc,
    output logic       vc,
    output vga_sync_t  sync_raw,
    output logic       frame_start
);

    localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic [31:0]   h_pos, v_pos;
    logic          h_last, v_last;
    logic          frame_par;

    assign h_pos  = 32'(hcount_q);
    assign v_pos  = 32'(vcount_q);
    assign h_last = (h_pos == HT - 1);
    assign v_last = (v_pos == VT - 1);

    always_comb begin
        hcount_d = hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (h_last) begin
            hcount_d = '0;
            vcount_d = v_last ? '0 : vcount_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else if (pix_ce) begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

`ifdef VGA_TEMPORAL_DITHER_EN
    logic frame_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_par_q <= 1'b0;
        end else if (pix_ce && h_last && v_last) begin
            frame_par_q <= ~frame_par_q;
        end
    end

    assign frame_par = frame_par_q;
`else
    assign frame_par = 1'b0;
`endif

    assign pix_x = 10'(hcount_q);
    assign pix_y = 10'(vcount_q);
    assign hc    = hcount_q[0] ^ frame_par;
    assign vc    = vcount_q[0] ^ frame_par;

    assign sync_raw.act = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    assign sync_raw.hs  = (h_pos >= H_ACTIVE + H_FP) &&
                          (h_pos <  H_ACTIVE + H_FP + H_SYNC);
    assign sync_raw.vs  = (v_pos >= V_ACTIVE + V_FP) &&
                          (v_pos <  V_ACTIVE + V_FP + V_SYNC);

    // Gated by rst_n so the pulse cannot appear while the counters are held in reset.
    assign frame_start = rst_n && pix_ce && (hcount_q == '0) && (vcount_q == '0);

endmodule

`default_nettype wire

// File: rtl/vga_pixel_out.sv
// ============================================================================
// Module   : vga_pixel_out
// Brief    : VGA timing plus two-stage colour/sync pipeline feeding the 4-bit
//            DACs. Optional macro: VGA_TEMPORAL_DITHER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_out
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_ce,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_req,
    output logic        hc,
    output logic        vc,
    input  logic [23:0] pix_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);

    vga_sync_t sync_raw;
    vga_sync_t sync1_q;
    rgb444_t   nib1_q;
    rgb444_t   rgb2_q;
    logic      hs2_q;
    logic      vs2_q;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_ce      (pix_ce),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .hc          (hc),
        .vc          (vc),
        .sync_raw    (sync_raw),
        .frame_start (frame_start)
    );

    assign pix_req = sync_raw.act;

    // Colour and sync travel through the same two stages so their phase never drifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib1_q  <= '0;
            sync1_q <= '0;
            rgb2_q  <= '0;
            hs2_q   <= ~SYNC_POL;
            vs2_q   <= ~SYNC_POL;
        end else if (pix_ce) begin
            nib1_q  <= rgb_nibbles(pix_in);
            sync1_q <= sync_raw;
            rgb2_q  <= sync1_q.act ? nib1_q : '0;
            hs2_q   <= sync1_q.hs ? SYNC_POL : ~SYNC_POL;
            vs2_q   <= sync1_q.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign vga_r  = rgb2_q.r;
    assign vga_g  = rgb2_q.g;
    assign vga_b  = rgb2_q.b;
    assign vga_hs = hs2_q;
    assign vga_vs = vs2_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
// ============================================================================
// Module   : tb_vga_pixel_out
// Brief    : Randomized self-checking bench: a reduced-timing DUT (active-high
//            sync) against a position-based reference model, plus a
//            default-timing DUT for line period and sync width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_out;

    localparam int   S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
    localparam int   S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int   S_VA = 8, S_VFP = 1, S_VS = 2, S_VBP = 2;
    localparam int   S_VT = S_VA + S_VFP + S_VS + S_VBP;
    localparam logic S_POL = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, pix_ce;
    logic [23:0] pix_in;
    logic [9:0]  pix_x, pix_y;
    logic        pix_req, hc, vc, hs, vs, fs;
    logic [3:0]  r, g, b;

    logic        rst_f, ce_f;
    logic [23:0] pix_in_f;
    logic [9:0]  f_x, f_y;
    logic        f_req, f_hc, f_vc, f_hs, f_vs, f_fs;
    logic [3:0]  f_r, f_g, f_b;

    vga_pixel_out #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .SYNC_POL(S_POL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .hc(hc), .vc(vc),
        .pix_in(pix_in), .vga_r(r), .vga_g(g), .vga_b(b),
        .vga_hs(hs), .vga_vs(vs), .frame_start(fs)
    );

    vga_pixel_out dut_full (
        .clk(clk), .rst_n(rst_f), .pix_ce(ce_f),
        .pix_x(f_x), .pix_y(f_y), .pix_req(f_req), .hc(f_hc), .vc(f_vc),
        .pix_in(pix_in_f), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
        .vga_hs(f_hs), .vga_vs(f_vs), .frame_start(f_fs)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n = 0;
    int          nf = 0;
    int          last_fall = -1;
    logic        f_hs_prev = 1'b1;
    logic [23:0] hist [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Expected outputs follow from the number of ce-ticks since reset alone.
    task automatic check_small();
        int x, y, p, px, py;
        logic par, act, ehs, evs;
        logic [23:0] col;
        logic [11:0] ergb;
        x = n % S_HT;
        y = (n / S_HT) % S_VT;
        par = 1'b0;
`ifdef VGA_TEMPORAL_DITHER_EN
        par = ((n / (S_HT * S_VT)) % 2) == 1;
`endif
        chk("pix_x", 32'(pix_x), 32'(x));
        chk("pix_y", 32'(pix_y), 32'(y));
        chk("pix_req", 32'(pix_req), 32'(x < S_HA && y < S_VA));
        chk("hc_vc", 32'({hc, vc}), 32'({x[0] ^ par, y[0] ^ par}));
        chk("frame_start", 32'(fs), 32'(pix_ce && (n % (S_HT * S_VT) == 0)));
        if (n < 2) begin
            ergb = 12'h000;
            ehs  = ~S_POL;
            evs  = ~S_POL;
        end else begin
            p    = n - 2;
            px   = p % S_HT;
            py   = (p / S_HT) % S_VT;
            act  = (px < S_HA) && (py < S_VA);
            col  = hist[p % 4];
            ergb = act ? {col[23:20], col[15:12], col[7:4]} : 12'h000;
            ehs  = (px >= S_HA + S_HFP && px < S_HA + S_HFP + S_HS) ? S_POL : ~S_POL;
            evs  = (py >= S_VA + S_VFP && py < S_VA + S_VFP + S_VS) ? S_POL : ~S_POL;
        end
        chk("rgb", 32'({r, g, b}), 32'(ergb));
        chk("sync", 32'({hs, vs}), 32'({ehs, evs}));
    endtask

    task automatic check_full();
        int p, px;
        logic [11:0] ergb;
        logic ehs;
        chk("f_pix_x", 32'(f_x), 32'(nf % 800));
        chk("f_pix_y", 32'(f_y), 32'(nf / 800));
        if (nf < 2) begin
            ergb = 12'h000;
            ehs  = 1'b1;
        end else begin
            p    = nf - 2;
            px   = p % 800;
            ergb = (px < 640) ? 12'hACF : 12'h000;
            ehs  = (px >= 656 && px < 752) ? 1'b0 : 1'b1;
        end
        chk("f_rgb", 32'({f_r, f_g, f_b}), 32'(ergb));
        chk("f_sync", 32'({f_hs, f_vs}), 32'({ehs, 1'b1}));
        if (f_hs_prev && !f_hs) begin
            if (last_fall >= 0) chk("f_hs_period", 32'(nf - last_fall), 32'd800);
            last_fall = nf;
        end
        if (!f_hs_prev && f_hs && last_fall >= 0) chk("f_hs_width", 32'(nf - last_fall), 32'd96);
        f_hs_prev = f_hs;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
        chk({tag, "_sync"}, 32'({hs, vs}), 32'({~S_POL, ~S_POL}));
        chk({tag, "_pos"}, 32'({pix_x, pix_y}), 32'd0);
        chk({tag, "_req"}, 32'(pix_req), 32'd1);
        chk({tag, "_hcvc"}, 32'({hc, vc}), 32'd0);
        chk({tag, "_fs"}, 32'(fs), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        rst_f    = 1'b0;
        pix_ce   = 1'b1;
        ce_f     = 1'b1;
        pix_in   = 24'h0;
        pix_in_f = 24'hA5C3F0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        chk("f_reset_sync", 32'({f_hs, f_vs, f_fs}), 32'({1'b1, 1'b1, 1'b0}));
        rst_n  = 1'b1;
        rst_f  = 1'b1;
        pix_in = 24'($urandom);

        for (cyc = 0; cyc < 4800; cyc++) begin
            @(negedge clk);
            check_small();
            if (cyc < 1700) check_full();
            if (pix_ce) begin
                hist[n % 4] = pix_in;
                n++;
            end
            nf++;
            @(posedge clk);
            #1;
            pix_in = 24'($urandom);
            if (cyc < 800)       pix_ce = 1'b1;
            else if (cyc < 3800) pix_ce = (cyc % 4 == 3);
            else                 pix_ce = 1'($urandom_range(0, 1));
            if (cyc == 4300) begin
                rst_n  = 1'b0;
                pix_ce = 1'b1;
                #1;
                check_reset("midreset");
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                n     = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
